// File: rtl/mem_xfer_seq.sv
// Byte-serial memory transfer sequencer: moves 1/2/4 little-endian bytes over an 8-bit bus, forming seg:off addresses.
// Define XFER_SEGWRAP_EN to wrap byte offsets inside the 64 KiB segment instead of carrying linearly.
module mem_xfer_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic [15:0]       seg,
  input  logic [15:0]       off,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        data,
  output logic [7:0]        out,
  output logic              wren,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_BYTES = DATA_W / 8;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned SUM_W     = (ADDR_W > 21) ? ADDR_W : 21;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt, idx_inc;
  logic [IDX_W-1:0]   cap_idx, cap_nxt;
  logic               primed, primed_nxt;
  logic [IDX_W-1:0]   last_q, last_nxt, last_c;
  logic [15:0]        seg_q, seg_nxt;
  logic [15:0]        off_q, off_nxt;
  logic [DATA_W-1:0]  wdata_q, wdata_nxt;
  logic [ADDR_W-1:0]  address_nxt;
  logic [7:0]         out_nxt;
  logic               wren_nxt;
  logic [DATA_W-1:0]  rdata_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  // Linear address of byte i of a transfer
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [15:0] s, input logic [15:0] o,
                                                  input logic [IDX_W-1:0] i);
    logic [SUM_W-1:0] sum;
`ifdef XFER_SEGWRAP_EN
    sum = SUM_W'({s, 4'h0}) + SUM_W'(16'(o + 16'(i)));
`else
    sum = SUM_W'({s, 4'h0}) + SUM_W'(o) + SUM_W'(i);
`endif
    return ADDR_W'(sum);
  endfunction

  function automatic logic [7:0] wbyte(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i);
    return 8'(w >> {i, 3'b000});
  endfunction

  // Index of the final byte; reserved size acts as dword, clamped to the data width
  assign last_c  = (size == 2'd0) ? IDX_W'(0) :
                   (size == 2'd1) ? IDX_W'(1) : IDX_W'(MAX_BYTES - 1);
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      cap_idx <= '0;
      primed  <= 1'b0;
      last_q  <= '0;
      seg_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      address <= '0;
      out     <= '0;
      wren    <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cap_idx <= cap_nxt;
      primed  <= primed_nxt;
      last_q  <= last_nxt;
      seg_q   <= seg_nxt;
      off_q   <= off_nxt;
      wdata_q <= wdata_nxt;
      address <= address_nxt;
      out     <= out_nxt;
      wren    <= wren_nxt;
      rdata   <= rdata_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Reads are pipelined: address i+1 goes out while byte i-1 is captured, one edge behind
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cap_nxt     = cap_idx;
    primed_nxt  = primed;
    last_nxt    = last_q;
    seg_nxt     = seg_q;
    off_nxt     = off_q;
    wdata_nxt   = wdata_q;
    address_nxt = address;
    out_nxt     = out;
    wren_nxt    = 1'b0;
    rdata_nxt   = rdata;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          seg_nxt     = seg;
          off_nxt     = off;
          wdata_nxt   = wdata;
          last_nxt    = last_c;
          idx_nxt     = '0;
          cap_nxt     = '0;
          primed_nxt  = 1'b0;
          busy_nxt    = 1'b1;
          address_nxt = byte_addr(seg, off, '0);
          if (!rw) begin
            out_nxt   = wdata[7:0];
            wren_nxt  = 1'b1;
            state_nxt = WR;
          end else begin
            rdata_nxt = '0;
            state_nxt = RD;
          end
        end
      end
      WR: begin
        if (idx != last_q) begin
          idx_nxt     = idx_inc;
          address_nxt = byte_addr(seg_q, off_q, idx_inc);
          out_nxt     = wbyte(wdata_q, idx_inc);
          wren_nxt    = 1'b1;
        end else begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD: begin
        if (idx != last_q) begin
          idx_nxt     = idx_inc;
          address_nxt = byte_addr(seg_q, off_q, idx_inc);
        end
        if (!primed) begin
          primed_nxt = 1'b1;
        end else begin
          for (int unsigned b = 0; b < MAX_BYTES; b++) begin
            if (cap_idx == IDX_W'(b)) rdata_nxt[8*b +: 8] = data;
          end
          if (cap_idx == last_q) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cap_nxt = cap_idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_xfer_seq.sv
// Directed bench for mem_xfer_seq: table of transfers on a 32-bit instance plus reset, back-to-back and 16-bit cases.
module tb_mem_xfer_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, rw;
  logic [1:0]  size;
  logic [15:0] seg, off;
  logic [31:0] wdata;
  logic [19:0] address;
  logic [7:0]  data, out;
  logic        wren, busy, done;
  logic [31:0] rdata;

  logic        start16, rw16;
  logic [1:0]  size16;
  logic [15:0] seg16, off16;
  logic [15:0] wdata16;
  logic [19:0] address16;
  logic [7:0]  data16, out16;
  logic        wren16, busy16, done16;
  logic [15:0] rdata16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [27:0] wlog[$];
  logic [27:0] wlog16[$];

  mem_xfer_seq #(.DATA_W(32), .ADDR_W(20)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .rw(rw), .size(size), .seg(seg), .off(off),
    .wdata(wdata), .address(address), .data(data), .out(out), .wren(wren), .rdata(rdata),
    .busy(busy), .done(done));

  mem_xfer_seq #(.DATA_W(16), .ADDR_W(20)) dut16 (
    .clock(clock), .reset_n(reset_n), .start(start16), .rw(rw16), .size(size16), .seg(seg16),
    .off(off16), .wdata(wdata16), .address(address16), .data(data16), .out(out16), .wren(wren16),
    .rdata(rdata16), .busy(busy16), .done(done16));

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    case (a)
      20'h02000: return 8'h34;
      20'h02001: return 8'h12;
      default:   return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Synchronous-read memory and write loggers
  always @(posedge clock) begin
    data   <= mem_rd(address);
    data16 <= mem_rd(address16);
    if (wren)   wlog.push_back({address, out});
    if (wren16) wlog16.push_back({address16, out16});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             rw;
    logic [1:0]       size;
    logic [15:0]      seg;
    logic [15:0]      off;
    logic [31:0]      wdata;
    int               n;
    logic [3:0][19:0] ea;
    logic [31:0]      erd;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string tag);
    int k;
    @(negedge clock);
    rw = v.rw; size = v.size; seg = v.seg; off = v.off; wdata = v.wdata; start = 1'b1;
    wlog.delete();
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    // Scramble inputs and pulse start while busy; none of it may matter
    k = 0;
    while (k < 12) begin
      @(posedge clock); #1;
      k++;
      if (done) break;
      if (k == 1) begin
        start = 1'b1; rw = ~v.rw; size = 2'd0; seg = 16'hAAAA; off = 16'h5555; wdata = 32'h0F0F0F0F;
      end
      if (k == 2) start = 1'b0;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(k), v.rw ? 64'(v.n + 1) : 64'(v.n));
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " wren at done"}, 64'(wren), 64'd0);
    if (v.rw) begin
      check({tag, " rdata"}, 64'(rdata), 64'(v.erd));
      check({tag, " no writes"}, 64'(wlog.size()), 64'd0);
    end else begin
      check({tag, " write count"}, 64'(wlog.size()), 64'(v.n));
      for (int i = 0; i < v.n && i < wlog.size(); i++)
        check({tag, " write byte"}, 64'(wlog[i]), 64'({v.ea[i], v.wdata[8*i +: 8]}));
    end
  endtask

  initial begin
    int k;
    vecs[0] = '{1'b0, 2'd2, 16'h1000, 16'h0010, 32'hDDCCBBAA, 4,
                {20'h10013, 20'h10012, 20'h10011, 20'h10010}, 32'h0};
    vecs[1] = '{1'b1, 2'd1, 16'h0200, 16'h0000, 32'h0, 2, 80'h0, 32'h00001234};
    vecs[2] = '{1'b1, 2'd2, 16'h0200, 16'h0000, 32'h0, 4, 80'h0, 32'hA6A71234};
    vecs[3] = '{1'b1, 2'd0, 16'h0200, 16'h0001, 32'h0, 1, 80'h0, 32'h00000012};
    vecs[4] = '{1'b0, 2'd0, 16'h0000, 16'h0100, 32'h11223344, 1,
                {60'h0, 20'h00100}, 32'h0};
    vecs[5] = '{1'b0, 2'd3, 16'hFFFF, 16'h0010, 32'h01020304, 4,
                {20'h00003, 20'h00002, 20'h00001, 20'h00000}, 32'h0};
`ifdef XFER_SEGWRAP_EN
    vecs[6] = '{1'b0, 2'd1, 16'h0000, 16'hFFFF, 32'h0000BEEF, 2,
                {40'h0, 20'h00000, 20'h0FFFF}, 32'h0};
`else
    vecs[6] = '{1'b0, 2'd1, 16'h0000, 16'hFFFF, 32'h0000BEEF, 2,
                {40'h0, 20'h10000, 20'h0FFFF}, 32'h0};
`endif

    reset_n = 1'b0;
    start = 1'b0; rw = 1'b0; size = 2'd0; seg = '0; off = '0; wdata = '0;
    start16 = 1'b0; rw16 = 1'b0; size16 = 2'd0; seg16 = '0; off16 = '0; wdata16 = '0;
    #12;
    check("reset address", 64'(address), 64'd0);
    check("reset out", 64'(out), 64'd0);
    check("reset wren", 64'(wren), 64'd0);
    check("reset rdata", 64'(rdata), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset16 rdata", 64'(rdata16), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a dword write
    @(negedge clock);
    rw = 1'b0; size = 2'd2; seg = 16'h1000; off = 16'h0010; wdata = 32'hDDCCBBAA; start = 1'b1;
    wlog.delete();
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("midreset wren", 64'(wren), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset address", 64'(address), 64'd0);
    check("midreset bytes written", 64'(wlog.size()), 64'd2);
    @(negedge clock);
    reset_n = 1'b1;
    run_vec(vecs[0], "after reset");

    // Back-to-back: start held through done, byte write then byte read
    @(negedge clock);
    rw = 1'b0; size = 2'd0; seg = 16'h0000; off = 16'h0100; wdata = 32'h0000005A; start = 1'b1;
    wlog.delete();
    @(posedge clock); #1;
    check("b2b write addr", 64'(address), 64'h00100);
    rw = 1'b1; seg = 16'h0200; off = 16'h0000;
    @(posedge clock); #1;
    check("b2b first done", 64'(done), 64'd1);
    @(posedge clock); #1;
    check("b2b second accepted", 64'(busy), 64'd1);
    check("b2b read addr", 64'(address), 64'h02000);
    start = 1'b0;
    k = 0;
    while (k < 10 && !done) begin
      @(posedge clock); #1;
      k++;
    end
    check("b2b read latency", 64'(k), 64'd2);
    check("b2b rdata", 64'(rdata), 64'h00000034);
    check("b2b write count", 64'(wlog.size()), 64'd1);
    check("b2b write byte", 64'(wlog.size() > 0 ? wlog[0] : 28'h0), 64'({20'h00100, 8'h5A}));

    // 16-bit instance: dword request clamps to 2 bytes
    @(negedge clock);
    rw16 = 1'b0; size16 = 2'd2; seg16 = 16'h0000; off16 = 16'h0200; wdata16 = 16'h5678; start16 = 1'b1;
    wlog16.delete();
    @(posedge clock); #1;
    start16 = 1'b0;
    k = 0;
    while (k < 10 && !done16) begin
      @(posedge clock); #1;
      k++;
    end
    check("w16 latency", 64'(k), 64'd2);
    check("w16 write count", 64'(wlog16.size()), 64'd2);
    check("w16 byte0", 64'(wlog16.size() > 0 ? wlog16[0] : 28'h0), 64'({20'h00200, 8'h78}));
    check("w16 byte1", 64'(wlog16.size() > 1 ? wlog16[1] : 28'h0), 64'({20'h00201, 8'h56}));
    @(negedge clock);
    rw16 = 1'b1; size16 = 2'd3; seg16 = 16'h0200; off16 = 16'h0000; start16 = 1'b1;
    @(posedge clock); #1;
    start16 = 1'b0;
    k = 0;
    while (k < 10 && !done16) begin
      @(posedge clock); #1;
      k++;
    end
    check("r16 latency", 64'(k), 64'd3);
    check("r16 rdata", 64'(rdata16), 64'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
